// File: rtl/mcs4_axi_burst_master.sv
// AXI4 INCR burst master: turns "write/read N beats at address A" commands into
// AW/W/B or AR/R channel traffic, with pass-through data streams and a done/resp pulse.
module mcs4_axi_burst_master #(
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 1,
  parameter int MAX_LEN = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  // command interface
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [7:0]            cmd_len,
  // write-data stream
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  // read-data stream
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_last,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  // completion
  output logic                  done,
  output logic [1:0]            done_resp,
  output logic                  busy,
  // AXI write address
  output logic [ID_W-1:0]       m_axi_awid,
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic [3:0]            m_axi_awqos,
  output logic [3:0]            m_axi_awregion,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  // AXI write data
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  // AXI write response
  input  logic [ID_W-1:0]       m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  // AXI read address
  output logic [ID_W-1:0]       m_axi_arid,
  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic [3:0]            m_axi_arqos,
  output logic [3:0]            m_axi_arregion,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  // AXI read data
  input  logic [ID_W-1:0]       m_axi_rid,
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int         BYTES   = DATA_W / 8;
  localparam int         LSB     = $clog2(BYTES);
  localparam logic [2:0] AX_SIZE = 3'(LSB);
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, ERR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [7:0]        beat_cnt;
  logic [1:0]        rresp_acc;

  logic [ADDR_W-1:0] cmd_addr_al;
  logic [13:0]       burst_bytes;
  logic [13:0]       burst_end;
  logic              cmd_cross;
  logic              cmd_too_long;
  logic [1:0]        rresp_next;
  logic              unused_in;

  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (b > a) ? b : a;
  endfunction

  // Command screening: sub-word address bits dropped, then length and 4 KB page checks.
  assign cmd_addr_al  = {cmd_addr[ADDR_W-1:LSB], {LSB{1'b0}}};
  assign burst_bytes  = ({6'd0, cmd_len} + 14'd1) << LSB;
  assign burst_end    = {2'b00, cmd_addr_al[11:0]} + burst_bytes;
  assign cmd_cross    = burst_end > 14'd4096;
  assign cmd_too_long = {24'd0, cmd_len} >= 32'(MAX_LEN);

  assign rresp_next = resp_max(rresp_acc, m_axi_rresp);

  // IDs are always 0, so returned IDs carry no information; low address bits are discarded.
  assign unused_in = ^{m_axi_bid, m_axi_rid, cmd_addr[LSB-1:0]};

  assign m_axi_awid     = '0;
  assign m_axi_awaddr   = addr_q;
  assign m_axi_awlen    = len_q;
  assign m_axi_awsize   = AX_SIZE;
  assign m_axi_awburst  = 2'b01;
  assign m_axi_awlock   = 1'b0;
  assign m_axi_awcache  = 4'd0;
  assign m_axi_awprot   = 3'd0;
  assign m_axi_awqos    = 4'd0;
  assign m_axi_awregion = 4'd0;

  assign m_axi_arid     = '0;
  assign m_axi_araddr   = addr_q;
  assign m_axi_arlen    = len_q;
  assign m_axi_arsize   = AX_SIZE;
  assign m_axi_arburst  = 2'b01;
  assign m_axi_arlock   = 1'b0;
  assign m_axi_arcache  = 4'd0;
  assign m_axi_arprot   = 3'd0;
  assign m_axi_arqos    = 4'd0;
  assign m_axi_arregion = 4'd0;

  // Data streams are combinational pass-throughs gated by the registered state.
  assign m_axi_wdata  = wr_data;
  assign m_axi_wstrb  = '1;
  assign m_axi_wvalid = (state == W) && wr_valid;
  assign wr_ready     = (state == W) && m_axi_wready;
  assign m_axi_wlast  = (state == W) && (beat_cnt == len_q);

  assign rd_data      = m_axi_rdata;
  assign rd_valid     = (state == R) && m_axi_rvalid;
  assign rd_last      = (state == R) && m_axi_rlast;
  assign m_axi_rready = (state == R) && rd_ready;

  always_ff @(posedge clk) begin
    if (state == IDLE && cmd_valid) begin
      addr_q <= cmd_addr_al;
      len_q  <= cmd_len;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cmd_ready     <= 1'b1;
      m_axi_awvalid <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_bready  <= 1'b0;
      done          <= 1'b0;
      done_resp     <= 2'b00;
      busy          <= 1'b0;
      beat_cnt      <= 8'd0;
      rresp_acc     <= 2'b00;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            beat_cnt  <= 8'd0;
            rresp_acc <= 2'b00;
            if (cmd_too_long || cmd_cross) begin
              state     <= ERR;
              done      <= 1'b1;
              done_resp <= RESP_SLVERR;
            end else if (cmd_write) begin
              state         <= AW;
              m_axi_awvalid <= 1'b1;
              busy          <= 1'b1;
            end else begin
              state         <= AR;
              m_axi_arvalid <= 1'b1;
              busy          <= 1'b1;
            end
          end
        end
        AW: begin
          if (m_axi_awready) begin
            m_axi_awvalid <= 1'b0;
            state         <= W;
          end
        end
        W: begin
          if (m_axi_wvalid && m_axi_wready) begin
            if (m_axi_wlast) begin
              state        <= B;
              m_axi_bready <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
            end
          end
        end
        B: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            state        <= IDLE;
            done         <= 1'b1;
            done_resp    <= m_axi_bresp;
            busy         <= 1'b0;
            cmd_ready    <= 1'b1;
          end
        end
        AR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            state         <= R;
          end
        end
        R: begin
          if (m_axi_rvalid && rd_ready) begin
            rresp_acc <= rresp_next;
            beat_cnt  <= beat_cnt + 8'd1;
            // A slave that never raises rlast still terminates the burst, flagged as an error.
            if (m_axi_rlast || beat_cnt == len_q) begin
              state     <= IDLE;
              done      <= 1'b1;
              done_resp <= m_axi_rlast ? rresp_next : RESP_SLVERR;
              busy      <= 1'b0;
              cmd_ready <= 1'b1;
            end
          end
        end
        ERR: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcs4_axi_burst_master.sv
// Directed bench for mcs4_axi_burst_master: a 32-bit/MAX_LEN=16 instance and a
// 64-bit/MAX_LEN=256 instance, AXI slave responses driven step by step.
module tb_mcs4_axi_burst_master;

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          errors = 0;

  // 32-bit instance
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [13:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [31:0] wr_data;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_data;
  logic        rd_last, rd_valid, rd_ready;
  logic        done;
  logic [1:0]  done_resp;
  logic        busy;
  logic [0:0]  m_axi_awid;
  logic [13:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awlock;
  logic [3:0]  m_axi_awcache;
  logic [2:0]  m_axi_awprot;
  logic [3:0]  m_axi_awqos, m_axi_awregion;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [0:0]  m_axi_bid;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid, m_axi_bready;
  logic [0:0]  m_axi_arid;
  logic [13:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arlock;
  logic [3:0]  m_axi_arcache;
  logic [2:0]  m_axi_arprot;
  logic [3:0]  m_axi_arqos, m_axi_arregion;
  logic        m_axi_arvalid, m_axi_arready;
  logic [0:0]  m_axi_rid;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

  // 64-bit instance
  logic        x_cmd_valid, x_cmd_ready, x_cmd_write;
  logic [13:0] x_cmd_addr;
  logic [7:0]  x_cmd_len;
  logic [63:0] x_wr_data;
  logic        x_wr_valid, x_wr_ready;
  logic [63:0] x_rd_data;
  logic        x_rd_last, x_rd_valid, x_rd_ready;
  logic        x_done;
  logic [1:0]  x_done_resp;
  logic        x_busy;
  logic [0:0]  x_awid;
  logic [13:0] x_unused_awaddr;
  logic [7:0]  x_unused_awlen;
  logic [2:0]  x_awsize;
  logic [1:0]  x_awburst;
  logic        x_awlock;
  logic [3:0]  x_awcache;
  logic [2:0]  x_awprot;
  logic [3:0]  x_awqos, x_awregion;
  logic        x_awvalid, x_awready;
  logic [63:0] x_wdata;
  logic [7:0]  x_wstrb;
  logic        x_wlast, x_wvalid, x_wready;
  logic [0:0]  x_bid;
  logic [1:0]  x_bresp;
  logic        x_bvalid, x_bready;
  logic [0:0]  x_arid;
  logic [13:0] x_araddr;
  logic [7:0]  x_arlen;
  logic [2:0]  x_arsize;
  logic [1:0]  x_arburst;
  logic        x_arlock;
  logic [3:0]  x_arcache;
  logic [2:0]  x_arprot;
  logic [3:0]  x_arqos, x_arregion;
  logic        x_arvalid, x_arready;
  logic [0:0]  x_rid;
  logic [63:0] x_rdata;
  logic [1:0]  x_rresp;
  logic        x_rlast, x_rvalid, x_rready;

  mcs4_axi_burst_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done(done), .done_resp(done_resp), .busy(busy),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_awregion(m_axi_awregion), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arregion(m_axi_arregion), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  mcs4_axi_burst_master #(.DATA_W(64), .MAX_LEN(256)) dut64 (
    .clk(clk), .rst(rst),
    .cmd_valid(x_cmd_valid), .cmd_ready(x_cmd_ready), .cmd_write(x_cmd_write),
    .cmd_addr(x_cmd_addr), .cmd_len(x_cmd_len),
    .wr_data(x_wr_data), .wr_valid(x_wr_valid), .wr_ready(x_wr_ready),
    .rd_data(x_rd_data), .rd_last(x_rd_last), .rd_valid(x_rd_valid), .rd_ready(x_rd_ready),
    .done(x_done), .done_resp(x_done_resp), .busy(x_busy),
    .m_axi_awid(x_awid), .m_axi_awaddr(x_unused_awaddr), .m_axi_awlen(x_unused_awlen),
    .m_axi_awsize(x_awsize), .m_axi_awburst(x_awburst), .m_axi_awlock(x_awlock),
    .m_axi_awcache(x_awcache), .m_axi_awprot(x_awprot), .m_axi_awqos(x_awqos),
    .m_axi_awregion(x_awregion), .m_axi_awvalid(x_awvalid), .m_axi_awready(x_awready),
    .m_axi_wdata(x_wdata), .m_axi_wstrb(x_wstrb), .m_axi_wlast(x_wlast),
    .m_axi_wvalid(x_wvalid), .m_axi_wready(x_wready),
    .m_axi_bid(x_bid), .m_axi_bresp(x_bresp), .m_axi_bvalid(x_bvalid), .m_axi_bready(x_bready),
    .m_axi_arid(x_arid), .m_axi_araddr(x_araddr), .m_axi_arlen(x_arlen),
    .m_axi_arsize(x_arsize), .m_axi_arburst(x_arburst), .m_axi_arlock(x_arlock),
    .m_axi_arcache(x_arcache), .m_axi_arprot(x_arprot), .m_axi_arqos(x_arqos),
    .m_axi_arregion(x_arregion), .m_axi_arvalid(x_arvalid), .m_axi_arready(x_arready),
    .m_axi_rid(x_rid), .m_axi_rdata(x_rdata), .m_axi_rresp(x_rresp),
    .m_axi_rlast(x_rlast), .m_axi_rvalid(x_rvalid), .m_axi_rready(x_rready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    int  k;
    bit  stalled;

    rst = 1'b1;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_valid = 0; rd_ready = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bid = '0; m_axi_bresp = '0; m_axi_bvalid = 0;
    m_axi_arready = 0; m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0;
    m_axi_rlast = 0; m_axi_rvalid = 0;
    x_cmd_valid = 0; x_cmd_write = 0; x_cmd_addr = '0; x_cmd_len = '0;
    x_wr_data = '0; x_wr_valid = 0; x_rd_ready = 0;
    x_awready = 0; x_wready = 0; x_bid = '0; x_bresp = '0; x_bvalid = 0;
    x_arready = 0; x_rid = '0; x_rdata = '0; x_rresp = '0; x_rlast = 0; x_rvalid = 0;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_done_resp", done_resp, 0);
    check("rst_valids", {m_axi_awvalid, m_axi_arvalid, m_axi_wvalid, m_axi_bready, m_axi_rready}, 0);
    check("rst_streams", {wr_ready, rd_valid, rd_last}, 0);
    check("tieoffs", {m_axi_awid, m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awregion,
                      m_axi_arid, m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arregion}, 0);
    check("x_rst_cmd_ready", x_cmd_ready, 1);

    // ---------------- write 4 beats at 0x100 ----------------
    m_axi_awready = 1; m_axi_wready = 1;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 14'h100; cmd_len = 8'd3;
    @(negedge clk);
    cmd_valid = 0; wr_valid = 1; wr_data = 32'h1;
    #1;
    check("wr_awvalid", m_axi_awvalid, 1);
    check("wr_awaddr", m_axi_awaddr, 14'h100);
    check("wr_awlen", m_axi_awlen, 3);
    check("wr_awsize", m_axi_awsize, 2);
    check("wr_awburst", m_axi_awburst, 1);
    check("wr_busy", busy, 1);
    check("wr_cmd_ready", cmd_ready, 0);
    check("wr_wvalid_in_aw", m_axi_wvalid, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wr_data = 32'(i + 1);
      #1;
      check("wr_wvalid", m_axi_wvalid, 1);
      check("wr_wready_pass", wr_ready, 1);
      check("wr_wdata", m_axi_wdata, 32'(i + 1));
      check("wr_wstrb", m_axi_wstrb, 4'hF);
      check("wr_wlast", m_axi_wlast, (i == 3));
    end
    @(negedge clk);
    wr_valid = 0; m_axi_bvalid = 1; m_axi_bresp = 2'b00;
    #1;
    check("wr_bready", m_axi_bready, 1);
    check("wr_wr_ready_in_b", wr_ready, 0);
    check("wr_done_before_b", done, 0);
    @(negedge clk);
    m_axi_bvalid = 0;
    #1;
    check("wr_done", done, 1);
    check("wr_done_resp", done_resp, 0);
    check("wr_done_cmd_ready", cmd_ready, 1);
    check("wr_done_busy", busy, 0);
    check("wr_bready_after", m_axi_bready, 0);
    @(negedge clk);
    #1;
    check("wr_done_pulse", done, 0);

    // ---------------- read-back 4 beats, rd_ready toggling ----------------
    m_axi_arready = 1;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 14'h100; cmd_len = 8'd3;
    @(negedge clk);
    cmd_valid = 0;
    #1;
    check("rd_arvalid", m_axi_arvalid, 1);
    check("rd_araddr", m_axi_araddr, 14'h100);
    check("rd_arlen", m_axi_arlen, 3);
    check("rd_arsize", m_axi_arsize, 2);
    check("rd_arburst", m_axi_arburst, 1);
    check("rd_awvalid", m_axi_awvalid, 0);
    k = 0;
    for (int c = 0; c < 16 && k < 4; c++) begin
      @(negedge clk);
      rd_ready = (c % 2 == 0);
      m_axi_rvalid = 1; m_axi_rdata = 32'(k + 1); m_axi_rlast = (k == 3); m_axi_rresp = 2'b00;
      #1;
      check("rd_rready_mirror", m_axi_rready, rd_ready);
      check("rd_valid", rd_valid, 1);
      check("rd_data", rd_data, 32'(k + 1));
      check("rd_last", rd_last, (k == 3));
      if (rd_ready) k++;
    end
    check("rd_beats", k, 4);
    @(negedge clk);
    m_axi_rvalid = 0; m_axi_rlast = 0; rd_ready = 0;
    #1;
    check("rd_done", done, 1);
    check("rd_done_resp", done_resp, 0);
    check("rd_cmd_ready", cmd_ready, 1);
    check("rd_rready_after", m_axi_rready, 0);

    // ---------------- 4 KB crossing ----------------
    wr_valid = 1; wr_data = 32'h55;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 14'hFF8; cmd_len = 8'd3;
    @(negedge clk);
    cmd_valid = 0;
    #1;
    check("x4k_done", done, 1);
    check("x4k_resp", done_resp, 2'b10);
    check("x4k_awvalid", m_axi_awvalid, 0);
    check("x4k_wvalid", m_axi_wvalid, 0);
    check("x4k_wr_ready", wr_ready, 0);
    @(negedge clk);
    #1;
    check("x4k_done_pulse", done, 0);
    check("x4k_cmd_ready", cmd_ready, 1);
    check("x4k_wr_ready2", wr_ready, 0);
    check("x4k_awvalid2", m_axi_awvalid, 0);
    wr_valid = 0;

    // ---------------- length >= MAX_LEN ----------------
    for (int t = 0; t < 2; t++) begin
      cmd_valid = 1; cmd_write = 0; cmd_addr = 14'h0; cmd_len = (t == 0) ? 8'd255 : 8'd16;
      @(negedge clk);
      cmd_valid = 0;
      #1;
      check("len_err_done", done, 1);
      check("len_err_resp", done_resp, 2'b10);
      check("len_err_arvalid", m_axi_arvalid, 0);
      @(negedge clk);
      #1;
      check("len_err_cmd_ready", cmd_ready, 1);
      check("len_err_arvalid2", m_axi_arvalid, 0);
    end

    // ---------------- backpressure, bresp SLVERR ----------------
    m_axi_awready = 0; m_axi_wready = 1; wr_valid = 1;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 14'h200; cmd_len = 8'd3;
    @(negedge clk);
    cmd_valid = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_awvalid_hold", m_axi_awvalid, 1);
      check("bp_awaddr_hold", m_axi_awaddr, 14'h200);
      check("bp_awlen_hold", m_axi_awlen, 3);
      check("bp_wvalid_stall", m_axi_wvalid, 0);
      @(negedge clk);
    end
    m_axi_awready = 1;
    #1;
    check("bp_awvalid_ready", m_axi_awvalid, 1);
    k = 0; stalled = 0;
    for (int c = 0; c < 16 && k < 4; c++) begin
      @(negedge clk);
      m_axi_awready = 0;
      if ((k == 1 || k == 2) && !stalled) begin
        m_axi_wready = 0; stalled = 1;
      end else begin
        m_axi_wready = 1; stalled = 0;
      end
      wr_data = 32'h10 + 32'(k);
      #1;
      check("bp_wr_ready_pass", wr_ready, m_axi_wready);
      check("bp_wvalid", m_axi_wvalid, 1);
      check("bp_wdata", m_axi_wdata, 32'h10 + 32'(k));
      check("bp_wlast", m_axi_wlast, (k == 3));
      if (m_axi_wready) k++;
    end
    check("bp_beats", k, 4);
    @(negedge clk);
    wr_valid = 0; m_axi_bvalid = 1; m_axi_bresp = 2'b10;
    #1;
    check("bp_bready", m_axi_bready, 1);
    @(negedge clk);
    m_axi_bvalid = 0; m_axi_bresp = 2'b00;
    #1;
    check("bp_done", done, 1);
    check("bp_done_resp", done_resp, 2'b10);

    // ---------------- mid-burst reset and recovery ----------------
    m_axi_arready = 1;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 14'h40; cmd_len = 8'd7;
    @(negedge clk);
    cmd_valid = 0;
    @(negedge clk);
    m_axi_rvalid = 1; m_axi_rdata = 32'h11; m_axi_rlast = 0; rd_ready = 1;
    #1;
    check("mr_beat1_valid", rd_valid, 1);
    @(negedge clk);
    m_axi_rdata = 32'h22;
    #1;
    check("mr_beat2_valid", rd_valid, 1);
    rst = 1'b1;
    #1;
    check("mr_rd_valid", rd_valid, 0);
    check("mr_rready", m_axi_rready, 0);
    check("mr_valids", {m_axi_awvalid, m_axi_arvalid, m_axi_wvalid, m_axi_bready, wr_ready}, 0);
    check("mr_busy", busy, 0);
    check("mr_done", done, 0);
    @(negedge clk);
    rst = 1'b0; m_axi_rvalid = 0; rd_ready = 0;
    #1;
    check("mr_cmd_ready", cmd_ready, 1);
    check("mr_rd_valid_after", rd_valid, 0);

    cmd_valid = 1; cmd_write = 0; cmd_addr = 14'h80; cmd_len = 8'd0;
    @(negedge clk);
    cmd_valid = 0;
    #1;
    check("s1_arvalid", m_axi_arvalid, 1);
    check("s1_araddr", m_axi_araddr, 14'h80);
    check("s1_arlen", m_axi_arlen, 0);
    @(negedge clk);
    m_axi_rvalid = 1; m_axi_rdata = 32'hABCD; m_axi_rlast = 1; m_axi_rresp = 2'b01; rd_ready = 1;
    #1;
    check("s1_rd_valid", rd_valid, 1);
    check("s1_rd_data", rd_data, 32'hABCD);
    check("s1_rd_last", rd_last, 1);
    @(negedge clk);
    m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rresp = 2'b00; rd_ready = 0;
    #1;
    check("s1_done", done, 1);
    check("s1_done_resp", done_resp, 2'b01);

    // ---------------- page-end single beat, unaligned address, missing rlast ----------------
    cmd_valid = 1; cmd_write = 0; cmd_addr = 14'hFFE; cmd_len = 8'd0;
    @(negedge clk);
    cmd_valid = 0;
    #1;
    check("pe_arvalid", m_axi_arvalid, 1);
    check("pe_araddr", m_axi_araddr, 14'hFFC);
    check("pe_done_none", done, 0);
    @(negedge clk);
    m_axi_rvalid = 1; m_axi_rdata = 32'h77; m_axi_rlast = 0; rd_ready = 1;
    #1;
    check("pe_rd_valid", rd_valid, 1);
    @(negedge clk);
    m_axi_rvalid = 0; rd_ready = 0;
    #1;
    check("pe_done", done, 1);
    check("pe_done_resp", done_resp, 2'b10);
    check("pe_cmd_ready", cmd_ready, 1);

    // ---------------- 64-bit, 256-beat read ----------------
    x_arready = 1;
    x_cmd_valid = 1; x_cmd_write = 0; x_cmd_addr = 14'h7; x_cmd_len = 8'd255;
    @(negedge clk);
    x_cmd_valid = 0;
    #1;
    check("w64_arvalid", x_arvalid, 1);
    check("w64_araddr", x_araddr, 14'h0);
    check("w64_arsize", x_arsize, 3);
    check("w64_arlen", x_arlen, 255);
    check("w64_arburst", x_arburst, 1);
    check("w64_busy", x_busy, 1);
    k = 0;
    for (int c = 0; c < 300 && k < 256; c++) begin
      @(negedge clk);
      x_rvalid = 1; x_rd_ready = 1;
      x_rdata = {32'(k), ~32'(k)}; x_rlast = (k == 255);
      #1;
      check("w64_rready", x_rready, 1);
      check("w64_rd_data", x_rd_data, {32'(k), ~32'(k)});
      check("w64_rd_last", x_rd_last, (k == 255));
      k++;
    end
    check("w64_beats", k, 256);
    @(negedge clk);
    x_rvalid = 0; x_rlast = 0; x_rd_ready = 0;
    #1;
    check("w64_done", x_done, 1);
    check("w64_done_resp", x_done_resp, 0);
    check("w64_cmd_ready", x_cmd_ready, 1);
    check("w64_rd_valid_after", x_rd_valid, 0);
    check("w64_write_idle", {x_awvalid, x_wvalid, x_wlast, x_bready, x_wr_ready}, 0);
    check("w64_wdata_pass", x_wdata, x_wr_data);
    check("w64_static", {x_awsize, x_awburst, x_wstrb}, {3'd3, 2'b01, 8'hFF});
    check("w64_tieoffs", {x_awid, x_awlock, x_awcache, x_awprot, x_awqos, x_awregion,
                          x_arid, x_arlock, x_arcache, x_arprot, x_arqos, x_arregion}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
